motor_segment_queue: RTL

MOTOR_SEGMENT_QUEUE -- requirements
Module: motor_segment_queue

---
 rtl/motor_segment_queue_pkg.sv | 21 ++
 rtl/motor_segment_queue_fifo.sv | 62 ++++++
 rtl/motor_segment_queue.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/motor_segment_queue_pkg.sv
// Shared types for the motor segment queue: segment record, field widths and FSM states.
package motor_pkg;

  localparam int DIV_W   = 15;
  localparam int STEPS_W = 14;
  localparam int POS_W   = 19;

  typedef struct packed {
    logic               dir;
    logic [DIV_W-1:0]   divider;
    logic [STEPS_W-1:0] steps;
  } seg_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    RUN        = 2'd3
  } state_t;

endpackage

// File: rtl/motor_segment_queue_fifo.sv
// seg_fifo: generic DEPTH-entry synchronous FIFO with occupancy output and synchronous clear.
module seg_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (cnt_r == FULL_CNT);
  assign empty     = (cnt_r == '0);
  assign level     = cnt_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full && !clr;
  assign do_pop_s  = pop && !empty && !clr;

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/motor_segment_queue.sv
// Motion segment queue feeding a step generator. Optional position counter: define SEGQ_POS_TRACK_EN.
module motor_segment_queue
  import motor_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic                      wr_dir,
  input  logic [DIV_W-1:0]          wr_divider,
  input  logic [STEPS_W-1:0]        wr_steps,
  input  logic                      flush,
  input  logic                      activeMode,
  input  logic                      step,
`ifdef SEGQ_POS_TRACK_EN
  input  logic                      pos_clear,
  output logic signed [POS_W-1:0]   pos,
`endif
  output logic [DIV_W-1:0]          divider,
  output logic [STEPS_W-1:0]        stepsToGo,
  output logic                      dir,
  output logic                      busy,
  output logic [CNT_W-1:0]          level
);

  state_t             state_r;
  state_t             state_s;
  logic               load_s;
  logic               push_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  seg_t               wr_seg_s;
  seg_t               head_s;
  logic               dir_r;
  logic [DIV_W-1:0]   div_r;
  logic [STEPS_W-1:0] steps_r;

  assign wr_ready = reset && !fifo_full_s && !flush;
  // Zero-length segments complete the handshake but are never stored.
  assign push_s   = wr_valid && wr_ready && (wr_steps != '0);
  assign pop_s    = (state_r == LOAD);
  assign wr_seg_s = '{dir: wr_dir, divider: wr_divider, steps: wr_steps};

  seg_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(seg_t)),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (reset),
    .clr   (flush),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wr_seg_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (level)
  );

  // Next-state logic; a flush in IDLE discards the head instead of issuing it.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s && !flush) begin
          state_s = LOAD;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: state_s = WAIT_START;
      WAIT_START: begin
        if (activeMode) state_s = RUN;
        else            state_s = WAIT_START;
      end
      RUN: begin
        if (!activeMode) state_s = IDLE;
        else             state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State and output registers; stepsToGo is non-zero only for the single LOAD cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      dir_r   <= 1'b0;
      div_r   <= '0;
      steps_r <= '0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        dir_r   <= head_s.dir;
        div_r   <= head_s.divider;
        steps_r <= head_s.steps;
      end else begin
        steps_r <= '0;
      end
    end
  end

  assign dir       = dir_r;
  assign divider   = div_r;
  assign stepsToGo = steps_r;
  assign busy      = (state_r != IDLE) || !fifo_empty_s;

`ifdef SEGQ_POS_TRACK_EN
  logic                    step_r;
  logic                    step_d_r;
  logic signed [POS_W-1:0] pos_r;

  // Registered step edge moves the position by one in the current direction; clear wins.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      step_r   <= 1'b0;
      step_d_r <= 1'b0;
      pos_r    <= '0;
    end else begin
      step_r   <= step;
      step_d_r <= step_r;
      if (pos_clear)                pos_r <= '0;
      else if (step_r && !step_d_r) pos_r <= dir_r ? (pos_r + 19'sd1) : (pos_r - 19'sd1);
      else                          pos_r <= pos_r;
    end
  end

  assign pos = pos_r;
`else
  logic unused_step_s;
  assign unused_step_s = step;
`endif

endmodule
